// File: rtl/enhanced_pkg.sv
// Shared constants for the enhanced accumulator processor.
// Opcodes, A-source selects and default widths.
package enhanced_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ADDSUB = 2'b00;
  localparam logic [1:0] ASEL_IN     = 2'b01;
  localparam logic [1:0] ASEL_MEM    = 2'b10;
  localparam logic [1:0] ASEL_ZERO   = 2'b11;

endpackage

// File: rtl/enhanced_ram.sv
// Unified program/data RAM: async read, sync write.
// Program-load port wins over the core write port.
module enhanced_ram
  import enhanced_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Pick the single write that happens this edge.
  always_comb begin
    wr_en   = core_we;
    wr_addr = core_addr;
    wr_data = core_wdata;
    if (prog_we) begin
      wr_en   = 1'b1;
      wr_addr = prog_addr;
      wr_data = prog_data;
    end
  end

  // Memory array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/enhanced_datapath.sv
// Accumulator datapath: PC, IR, A, add/sub and RAM.
// Driven by the control-unit FSM's control word.
module enhanced_datapath
  import enhanced_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IRload,
  input  logic              JMPmux,
  input  logic              PCload,
  input  logic              Meminst,
  input  logic              MemWr,
  input  logic [1:0]        Asel,
  input  logic              Aload,
  input  logic              Sub,
  input  logic              Halt,
  input  logic [DATA_W-1:0] input_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [2:0]        ir,
  output logic              Aeq0,
  output logic              Apos,
  output logic [DATA_W-1:0] output_value,
  output logic [ADDR_W-1:0] pc_value,
  output logic              halted
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic              halted_q, halted_d;

  logic [ADDR_W-1:0] ir_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] a_src;
  logic              run;

  assign ir_addr  = ir_q[ADDR_W-1:0];
  assign mem_addr = Meminst ? ir_addr : pc_q;
  assign run      = ~halted_q;

  enhanced_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk       (clock),
    .core_we   (MemWr & run & ~reset),
    .core_addr (mem_addr),
    .core_wdata(a_q),
    .prog_we   (prog_we & ~reset),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .raddr     (mem_addr),
    .rdata     (rdata)
  );

  // Add/sub unit and A source mux.
  always_comb begin
    alu_res = Sub ? (a_q - rdata) : (a_q + rdata);
    a_src   = '0;
    unique case (Asel)
      ASEL_ADDSUB: a_src = alu_res;
      ASEL_IN:     a_src = input_data;
      ASEL_MEM:    a_src = rdata;
      ASEL_ZERO:   a_src = '0;
    endcase
  end

  // Next-state for PC, IR, A and halt flag.
  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    halted_d = halted_q;
    if (run) begin
      if (PCload) pc_d = JMPmux ? ir_addr : pc_q + 1'b1;
      if (IRload) ir_d = rdata;
      if (Aload)  a_d  = a_src;
      if (Halt)   halted_d = 1'b1;
    end
  end

  // Architectural registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      halted_q <= halted_d;
    end
  end

  assign ir           = ir_q[DATA_W-1:DATA_W-3];
  assign Aeq0         = (a_q == '0);
  assign Apos         = ~a_q[DATA_W-1] & (a_q != '0);
  assign output_value = a_q;
  assign pc_value     = pc_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_enhanced_datapath.sv
// Directed self-checking bench for enhanced_datapath.
// One task per scenario, expected values hand-computed.
module tb_enhanced_datapath;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       IRload = 1'b0;
  logic       JMPmux = 1'b0;
  logic       PCload = 1'b0;
  logic       Meminst = 1'b0;
  logic       MemWr = 1'b0;
  logic [1:0] Asel = 2'b00;
  logic       Aload = 1'b0;
  logic       Sub = 1'b0;
  logic       Halt = 1'b0;
  logic [7:0] input_data = 8'h00;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = 5'd0;
  logic [7:0] prog_data = 8'h00;
  logic [2:0] ir;
  logic       Aeq0;
  logic       Apos;
  logic [7:0] output_value;
  logic [4:0] pc_value;
  logic       halted;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  enhanced_datapath dut (
    .clock       (clock),
    .reset       (reset),
    .IRload      (IRload),
    .JMPmux      (JMPmux),
    .PCload      (PCload),
    .Meminst     (Meminst),
    .MemWr       (MemWr),
    .Asel        (Asel),
    .Aload       (Aload),
    .Sub         (Sub),
    .Halt        (Halt),
    .input_data  (input_data),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .ir          (ir),
    .Aeq0        (Aeq0),
    .Apos        (Apos),
    .output_value(output_value),
    .pc_value    (pc_value),
    .halted      (halted)
  );

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    reset = 0; IRload = 0; JMPmux = 0; PCload = 0;
    Meminst = 0; MemWr = 0; Asel = 2'b00; Aload = 0;
    Sub = 0; Halt = 0; prog_we = 0;
  endtask

  task automatic prog(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1; prog_addr = a; prog_data = d;
    cyc();
    prog_we = 0;
  endtask

  task automatic set_a_in(input logic [7:0] d);
    Asel = 2'b01; input_data = d; Aload = 1;
    cyc();
    idle();
  endtask

  task automatic test_reset();
    reset = 1;
    cyc();
    idle();
    checks++;
    if (ir !== 3'b000) begin
      $display("FAIL reset_ir got %b exp 000", ir); errors++;
    end
    checks++;
    if (Aeq0 !== 1'b1) begin
      $display("FAIL reset_aeq0 got %b exp 1", Aeq0); errors++;
    end
    checks++;
    if (Apos !== 1'b0) begin
      $display("FAIL reset_apos got %b exp 0", Apos); errors++;
    end
    checks++;
    if (output_value !== 8'h00) begin
      $display("FAIL reset_a got %h exp 00", output_value); errors++;
    end
    checks++;
    if (pc_value !== 5'd0) begin
      $display("FAIL reset_pc got %0d exp 0", pc_value); errors++;
    end
    checks++;
    if (halted !== 1'b0) begin
      $display("FAIL reset_halted got %b exp 0", halted); errors++;
    end
  endtask

  task automatic test_load();
    prog(5'd0, 8'h05);
    prog(5'd5, 8'h0A);
    IRload = 1; PCload = 1; JMPmux = 0;
    cyc();
    idle();
    checks++;
    if (ir !== 3'b000) begin
      $display("FAIL fetch_ir got %b exp 000", ir); errors++;
    end
    checks++;
    if (pc_value !== 5'd1) begin
      $display("FAIL fetch_pc got %0d exp 1", pc_value); errors++;
    end
    Meminst = 1; Asel = 2'b10; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h0A) begin
      $display("FAIL load_a got %h exp 0a", output_value); errors++;
    end
    checks++;
    if (Aeq0 !== 1'b0 || Apos !== 1'b1) begin
      $display("FAIL load_flags got %b%b exp 01", Aeq0, Apos); errors++;
    end
  endtask

  task automatic test_addsub();
    prog(5'd6, 8'h03);
    prog(5'd1, 8'h46);
    IRload = 1; PCload = 1;
    cyc();
    idle();
    checks++;
    if (ir !== 3'b010 || pc_value !== 5'd2) begin
      $display("FAIL add_fetch got ir=%b pc=%0d exp 010/2", ir, pc_value); errors++;
    end
    Meminst = 1; Asel = 2'b00; Sub = 0; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h0D) begin
      $display("FAIL add got %h exp 0d", output_value); errors++;
    end
    prog(5'd6, 8'h0D);
    Meminst = 1; Asel = 2'b00; Sub = 1; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h00 || Aeq0 !== 1'b1) begin
      $display("FAIL sub_zero got %h aeq0=%b exp 00/1", output_value, Aeq0); errors++;
    end
    prog(5'd6, 8'h01);
    Meminst = 1; Asel = 2'b00; Sub = 1; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'hFF) begin
      $display("FAIL sub_neg got %h exp ff", output_value); errors++;
    end
    checks++;
    if (Apos !== 1'b0 || Aeq0 !== 1'b0) begin
      $display("FAIL sub_neg_flags got %b%b exp 00", Aeq0, Apos); errors++;
    end
    set_a_in(8'h7F);
    Meminst = 1; Asel = 2'b00; Sub = 0; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h80 || Apos !== 1'b0) begin
      $display("FAIL add_wrap got %h apos=%b exp 80/0", output_value, Apos); errors++;
    end
  endtask

  task automatic test_input_store();
    set_a_in(8'h80);
    checks++;
    if (output_value !== 8'h80 || Apos !== 1'b0) begin
      $display("FAIL input got %h apos=%b exp 80/0", output_value, Apos); errors++;
    end
    prog(5'd2, 8'h3F);
    IRload = 1; PCload = 1;
    cyc();
    idle();
    checks++;
    if (ir !== 3'b001 || pc_value !== 5'd3) begin
      $display("FAIL store_fetch got ir=%b pc=%0d exp 001/3", ir, pc_value); errors++;
    end
    Meminst = 1; MemWr = 1; Aload = 1; Asel = 2'b01; input_data = 8'h22;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h22) begin
      $display("FAIL store_aload got %h exp 22", output_value); errors++;
    end
    Meminst = 1; Asel = 2'b10; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h80) begin
      $display("FAIL store_readback got %h exp 80", output_value); errors++;
    end
  endtask

  task automatic test_jump_wrap();
    prog(5'd3, 8'hBE);
    IRload = 1;
    cyc();
    idle();
    checks++;
    if (ir !== 3'b101 || pc_value !== 5'd3) begin
      $display("FAIL jz_fetch got ir=%b pc=%0d exp 101/3", ir, pc_value); errors++;
    end
    PCload = 1; JMPmux = 1;
    cyc();
    idle();
    checks++;
    if (pc_value !== 5'd30) begin
      $display("FAIL jump got %0d exp 30", pc_value); errors++;
    end
    PCload = 1;
    cyc();
    checks++;
    if (pc_value !== 5'd31) begin
      $display("FAIL inc31 got %0d exp 31", pc_value); errors++;
    end
    cyc();
    idle();
    checks++;
    if (pc_value !== 5'd0) begin
      $display("FAIL wrap got %0d exp 0", pc_value); errors++;
    end
    IRload = 1; PCload = 1; JMPmux = 1;
    cyc();
    idle();
    checks++;
    if (pc_value !== 5'd30 || ir !== 3'b000) begin
      $display("FAIL jump_old_ir got pc=%0d ir=%b exp 30/000", pc_value, ir); errors++;
    end
  endtask

  task automatic test_halt();
    Halt = 1;
    cyc();
    idle();
    checks++;
    if (halted !== 1'b1) begin
      $display("FAIL halt_set got %b exp 1", halted); errors++;
    end
    Aload = 1; Asel = 2'b11; PCload = 1; IRload = 1;
    MemWr = 1; Meminst = 1;
    cyc();
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h80 || pc_value !== 5'd30) begin
      $display("FAIL halt_frozen got a=%h pc=%0d exp 80/30", output_value, pc_value); errors++;
    end
    checks++;
    if (ir !== 3'b000 || halted !== 1'b1) begin
      $display("FAIL halt_ir got ir=%b h=%b exp 000/1", ir, halted); errors++;
    end
    reset = 1;
    cyc();
    idle();
    checks++;
    if (halted !== 1'b0 || output_value !== 8'h00 || pc_value !== 5'd0) begin
      $display("FAIL halt_reset got h=%b a=%h pc=%0d exp 0/00/0", halted, output_value, pc_value); errors++;
    end
    prog(5'd0, 8'h3F);
    IRload = 1;
    cyc();
    idle();
    Meminst = 1; Asel = 2'b10; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h80) begin
      $display("FAIL ram_kept got %h exp 80", output_value); errors++;
    end
    prog(5'd0, 8'h05);
    IRload = 1;
    cyc();
    idle();
    Meminst = 1; Asel = 2'b10; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h0A) begin
      $display("FAIL halt_no_write got %h exp 0a", output_value); errors++;
    end
  endtask

  task automatic test_prog_priority();
    set_a_in(8'h22);
    prog(5'd0, 8'h04);
    IRload = 1;
    cyc();
    idle();
    prog_we = 1; prog_addr = 5'd4; prog_data = 8'h55;
    Meminst = 1; MemWr = 1;
    cyc();
    idle();
    Meminst = 1; Asel = 2'b10; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h55) begin
      $display("FAIL prog_priority got %h exp 55", output_value); errors++;
    end
  endtask

  task automatic test_reset_mid();
    reset = 1; Aload = 1; Asel = 2'b01; input_data = 8'h33;
    prog_we = 1; prog_addr = 5'd4; prog_data = 8'h99;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h00 || Aeq0 !== 1'b1) begin
      $display("FAIL reset_mid got %h aeq0=%b exp 00/1", output_value, Aeq0); errors++;
    end
    prog(5'd0, 8'h04);
    IRload = 1;
    cyc();
    idle();
    Meminst = 1; Asel = 2'b10; Aload = 1;
    cyc();
    idle();
    checks++;
    if (output_value !== 8'h55) begin
      $display("FAIL reset_blocks_prog got %h exp 55", output_value); errors++;
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_load();
    test_addsub();
    test_input_store();
    test_jump_wrap();
    test_halt();
    test_prog_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
